// File: rtl/openframe_gpio_cfg_pkg.sv
// Shared types and constants for the openframe GPIO configuration loader.
// Defines the pad word layout, its reset value and the loader FSM state encoding.
package openframe_gpio_cfg_pkg;

  localparam int unsigned CFG_W = 13;

  // Bit positions of each field inside one pad word
  localparam int unsigned DM_LSB      = 10;
  localparam int unsigned OEB_BIT     = 9;
  localparam int unsigned IEB_BIT     = 8;
  localparam int unsigned IB_MODE_BIT = 7;
  localparam int unsigned VTRIP_BIT   = 6;
  localparam int unsigned SLOW_BIT    = 5;
  localparam int unsigned AN_EN_BIT   = 4;
  localparam int unsigned AN_SEL_BIT  = 3;
  localparam int unsigned AN_POL_BIT  = 2;
  localparam int unsigned HOLD_BIT    = 1;
  localparam int unsigned INP_DIS_BIT = 0;

  localparam logic [CFG_W-1:0] CFG_RESET = 13'b001_1_0000_00000;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_COMMIT = 1'b1
  } cfg_state_e;

endpackage

// File: rtl/openframe_gpio_cfg_slot.sv
// Active configuration register for one pad; loads the shadow word on commit
// and fans the fields out to the individual pad control bits.
module openframe_gpio_cfg_slot
  import openframe_gpio_cfg_pkg::*;
(
  input  logic             clk,
  input  logic             resetb,
  input  logic             load,
  input  logic [CFG_W-1:0] d,
  output logic             dm2,
  output logic             dm1,
  output logic             dm0,
  output logic             oeb,
  output logic             ieb,
  output logic             ib_mode_sel,
  output logic             vtrip_sel,
  output logic             slow_sel,
  output logic             analog_en,
  output logic             analog_sel,
  output logic             analog_pol,
  output logic             holdover,
  output logic             inp_dis
);

  logic [CFG_W-1:0] q;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      q <= CFG_RESET;
    end else if (load) begin
      q <= d;
    end
  end

  assign dm2         = q[DM_LSB+2];
  assign dm1         = q[DM_LSB+1];
  assign dm0         = q[DM_LSB];
  assign oeb         = q[OEB_BIT];
  assign ieb         = q[IEB_BIT];
  assign ib_mode_sel = q[IB_MODE_BIT];
  assign vtrip_sel   = q[VTRIP_BIT];
  assign slow_sel    = q[SLOW_BIT];
  assign analog_en   = q[AN_EN_BIT];
  assign analog_sel  = q[AN_SEL_BIT];
  assign analog_pol  = q[AN_POL_BIT];
  assign holdover    = q[HOLD_BIT];
  assign inp_dis     = q[INP_DIS_BIT];

endmodule

// File: rtl/openframe_gpio_cfg_loader.sv
// Serial configuration loader for the openframe pad ring: shadow shift chain,
// bit counter and commit FSM. Optional readback capture under GPIO_CFG_READBACK_EN.
module openframe_gpio_cfg_loader
  import openframe_gpio_cfg_pkg::*;
#(
  parameter int unsigned NUM_PADS = 44
) (
  input  logic                clk,
  input  logic                resetb,
  input  logic                ser_data,
  input  logic                ser_shift,
  input  logic                ser_load,
`ifdef GPIO_CFG_READBACK_EN
  input  logic                ser_capture,
`endif
  output logic                ser_out,
  output logic                busy,
  output logic                cfg_done,
  output logic                cfg_err,
  output logic [NUM_PADS-1:0] gpio_dm2,
  output logic [NUM_PADS-1:0] gpio_dm1,
  output logic [NUM_PADS-1:0] gpio_dm0,
  output logic [NUM_PADS-1:0] gpio_oeb,
  output logic [NUM_PADS-1:0] gpio_ieb,
  output logic [NUM_PADS-1:0] gpio_ib_mode_sel,
  output logic [NUM_PADS-1:0] gpio_vtrip_sel,
  output logic [NUM_PADS-1:0] gpio_slow_sel,
  output logic [NUM_PADS-1:0] gpio_analog_en,
  output logic [NUM_PADS-1:0] gpio_analog_sel,
  output logic [NUM_PADS-1:0] gpio_analog_pol,
  output logic [NUM_PADS-1:0] gpio_holdover,
  output logic [NUM_PADS-1:0] gpio_inp_dis
);

  localparam int unsigned TOTAL = NUM_PADS * CFG_W;
  localparam int unsigned CNT_W = $clog2(TOTAL + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TOTAL);
  localparam logic [CNT_W-1:0] CNT_OVF  = CNT_W'(TOTAL + 1);

  cfg_state_e       state;
  logic [TOTAL-1:0] sr;
  logic [CNT_W-1:0] bit_cnt;
  logic             commit_c;

  assign commit_c = (state == ST_COMMIT);
  assign ser_out  = sr[TOTAL-1];

`ifdef GPIO_CFG_READBACK_EN
  // Live configuration reassembled in chain order for parallel capture
  logic [TOTAL-1:0] act_cfg;
  always_comb begin
    act_cfg = '0;
    for (int p = 0; p < int'(NUM_PADS); p++) begin
      act_cfg[p*CFG_W +: CFG_W] = {gpio_dm2[p], gpio_dm1[p], gpio_dm0[p], gpio_oeb[p],
                                   gpio_ieb[p], gpio_ib_mode_sel[p], gpio_vtrip_sel[p],
                                   gpio_slow_sel[p], gpio_analog_en[p], gpio_analog_sel[p],
                                   gpio_analog_pol[p], gpio_holdover[p], gpio_inp_dis[p]};
    end
  end
`endif

  // Chain, counter and commit FSM; load has priority over capture and shift
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state    <= ST_IDLE;
      sr       <= '0;
      bit_cnt  <= '0;
      busy     <= 1'b0;
      cfg_done <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      cfg_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ser_load) begin
            if (bit_cnt == CNT_FULL) begin
              state <= ST_COMMIT;
              busy  <= 1'b1;
            end else begin
              cfg_err <= 1'b1;
              bit_cnt <= '0;
            end
`ifdef GPIO_CFG_READBACK_EN
          end else if (ser_capture) begin
            sr      <= act_cfg;
            bit_cnt <= '0;
`endif
          end else if (ser_shift) begin
            sr <= {sr[TOTAL-2:0], ser_data};
            if (bit_cnt != CNT_OVF) begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end
        end
        ST_COMMIT: begin
          state    <= ST_IDLE;
          busy     <= 1'b0;
          cfg_done <= 1'b1;
          cfg_err  <= 1'b0;
          bit_cnt  <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar p = 0; p < int'(NUM_PADS); p++) begin : g_slot
    openframe_gpio_cfg_slot u_slot (
      .clk         (clk),
      .resetb      (resetb),
      .load        (commit_c),
      .d           (sr[p*CFG_W +: CFG_W]),
      .dm2         (gpio_dm2[p]),
      .dm1         (gpio_dm1[p]),
      .dm0         (gpio_dm0[p]),
      .oeb         (gpio_oeb[p]),
      .ieb         (gpio_ieb[p]),
      .ib_mode_sel (gpio_ib_mode_sel[p]),
      .vtrip_sel   (gpio_vtrip_sel[p]),
      .slow_sel    (gpio_slow_sel[p]),
      .analog_en   (gpio_analog_en[p]),
      .analog_sel  (gpio_analog_sel[p]),
      .analog_pol  (gpio_analog_pol[p]),
      .holdover    (gpio_holdover[p]),
      .inp_dis     (gpio_inp_dis[p])
    );
  end

endmodule
